xor_rr_arbiter: RTL
===================

Name: xor_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered bitwise XOR unit among N_REQ requesters. A requester presents two WIDTH-bit operands with a request. The block grants one requester at a time, captures its operands and runs the shared unit for LAT cycles. It then returns out = a ^ b, tagged with the requester index. It sits between operand producers and the gate-level XOR datapath, so the datapath is never instantiated per requester.

Parameters:
N_REQ, 4, number of requesters (>= 2)
WIDTH, 8, operand/result width in bits (>= 1)
LAT, 2, cycles from operand capture to result (>= 1; 0 is illegal)
ID_W (localparam), clog2(N_REQ) with a minimum of 1, width of out_id

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  request per requester; bit i belongs to requester i
a_bus  input  N_REQ*WIDTH  operand a; requester i at bits [i*WIDTH +: WIDTH]
b_bus  input  N_REQ*WIDTH  operand b; same packing as a_bus
gnt  output  N_REQ  one-hot grant pulse; asserted for the cycle after operand capture
busy  output  1  high while state != IDLE
out  output  WIDTH  result a ^ b of the last completed operation
out_valid  output  1  one-cycle pulse when out/out_id are new
out_id  output  ID_W  index of the requester whose result is on out

Behaviour:
- Reset (asynchronous, rst_n low): all of the following clear immediately.
  - state = IDLE; rr pointer last = N_REQ-1, so requester 0 has first priority.
  - gnt = 0, busy = 0, out = 0, out_valid = 0, out_id = 0, counter = 0.
- States: IDLE, EXEC, DONE. All outputs are registered.
- Arbitration point: every rising edge in IDLE or DONE with req != 0.
  - Winner = first set bit searching last+1, last+2, ... modulo N_REQ.
  - At that edge: capture the winner's a/b; gnt <= onehot(winner); id <= winner; last <= winner; cnt <= LAT-1; state <= EXEC.
- The arbitration edge is the capture edge E0. gnt is high only in the cycle after E0 and returns to 0 at the next edge.
- EXEC, each edge:
  - if cnt != 0: cnt decrements.
  - if cnt == 0: out <= a_reg ^ b_reg; out_id <= id; out_valid <= 1; state <= DONE.
- Latency: out_valid rises at edge E0+LAT.
- DONE: out_valid <= 0 at the next edge. Arbitration happens at that same edge.
  - If req != 0: back-to-back capture and state <= EXEC.
  - Otherwise: state <= IDLE.
- Throughput: one operation per LAT+1 cycles under continuous demand.
- Requester contract:
  - Hold req[i] and the operands stable until gnt[i] is observed.
  - Deassert req[i] before the next arbitration edge (E0+LAT+1). A req still high at that edge is a new request.
- Operand changes after the capture edge do not affect the in-flight result.
- req bits that drop before being granted are simply not considered; there is no queueing.
- out and out_id hold their values between out_valid pulses.
- Only one gnt bit is ever high, and only one operation is ever in flight.
- req == 0 in IDLE: state is unchanged and no outputs toggle.
- Reset mid-EXEC or mid-DONE: the operation is discarded, no out_valid is produced, and the pointer returns to N_REQ-1.
- busy is high from the edge after E0 until the edge where DONE returns to IDLE.

Test Plan:
- Reset: rst_n=0 with random req/operands -> gnt=0, busy=0, out=0, out_valid=0, out_id=0; values hold while rst_n stays low.
- Single op (LAT=2): req=4'b0001, a0=8'hA5, b0=8'h0F at E0 -> gnt=4'b0001 for exactly one cycle; out_valid at E0+2 with out=8'hAA, out_id=0; busy low one cycle after DONE.
- Truth table (WIDTH=1): via requester 1, (a,b) = (0,0), (0,1), (1,0), (1,1) -> out = 0, 1, 1, 0 with out_id=1 each time.
- Fairness: all four req held high -> grant order 0,1,2,3,0,1; out_valid every LAT+1=3 cycles; each out equals a_i^b_i of the granted index.
- Pointer wrap: after a grant to 2, req=4'b0101 -> next grant 0 (search order 3, 0); then req=4'b0101 -> grant 2.
- Operand change and reset: after gnt, change a0 -> result uses the captured value. Then pull rst_n low mid-EXEC -> no out_valid, all outputs 0. After release with req=4'b1001 -> grant 0 first.

Source files
------------

// File: rtl/xor_rr_arbiter.sv
// Round-robin arbiter sharing one registered XOR unit among N_REQ requesters.
// One operation in flight; result tagged with the granted requester index.
module xor_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int LAT   = 2,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_bus,
    input  logic [N_REQ*WIDTH-1:0] b_bus,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    output logic [ID_W-1:0]        out_id
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                ov_q, ov_d;
    logic [ID_W-1:0]     oid_q, oid_d;

    logic                found;
    logic [ID_W-1:0]     win;
    int                  idx;

    // Search starts just past the last winner and wraps around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        gnt_d   = '0;
        out_d   = out_q;
        ov_d    = 1'b0;
        oid_d   = oid_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (found) begin
                    a_d        = a_bus[int'(win)*WIDTH +: WIDTH];
                    b_d        = b_bus[int'(win)*WIDTH +: WIDTH];
                    gnt_d[win] = 1'b1;
                    id_d       = win;
                    last_d     = win;
                    cnt_d      = CNT_W'(LAT - 1);
                    state_d    = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_d   = a_q ^ b_q;
                    oid_d   = id_q;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            oid_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            oid_q   <= oid_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_valid = ov_q;
    assign out_id    = oid_q;

endmodule
